// File: rtl/abs_transfer_sequencer_if.sv
// Request/strobe bundle between the control unit and abs_transfer_sequencer.
// The master holds start with mode. The request is taken on an edge where the sequencer
// is idle or showing done. busy covers the whole transfer. done (or illegal, for a bad
// mode) pulses for exactly one cycle.
interface abs_transfer_sequencer_if;
  logic       start;
  logic [2:0] mode;
  logic       busy;
  logic       done;
  logic       illegal;
  logic       ir_fetch;
  logic [7:0] write8;
  logic [5:0] read16;
  logic [5:0] write16;
  logic [1:0] read_alu8;
  logic [1:0] write_alu8;
  logic [1:0] read_sp;
  logic       move_reg;
  logic       bus_in;
  logic       bus_out;
  logic       address_out;
  logic       high_page;
  logic [1:0] increment16;

  modport master (
    output start, mode,
    input  busy, done, illegal, ir_fetch, write8, read16, write16, read_alu8,
           write_alu8, read_sp, move_reg, bus_in, bus_out, address_out, high_page,
           increment16
  );

  modport slave (
    input  start, mode,
    output busy, done, illegal, ir_fetch, write8, read16, write16, read_alu8,
           write_alu8, read_sp, move_reg, bus_in, bus_out, address_out, high_page,
           increment16
  );
endinterface

// File: rtl/abs_transfer_sequencer.sv
// Self-timed sequencer for LD/LDH absolute transfers between A (or SP) and memory.
// Define ABS_TRANSFER_SP_STORE_EN to build the LD (a16),SP path (mode 100, DATA_HI state).
module abs_transfer_sequencer #(
  parameter int         STEPS     = 4,
  parameter logic [7:0] HIGH_PAGE = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  abs_transfer_sequencer_if.slave   bus,
  output logic [7:0]                page_addr,
  output logic [2:0]                dbg_state
);
  localparam int            SW    = $clog2(STEPS);
  localparam logic [SW-1:0] LAST  = SW'(STEPS - 1);
  localparam logic [SW-1:0] STEP1 = SW'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IMM_LO  = 3'd1,
    IMM_HI  = 3'd2,
    DATA_LO = 3'd3,
`ifdef ABS_TRANSFER_SP_STORE_EN
    DATA_HI = 3'd4,
`endif
    FETCH   = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] step, step_n;
  logic [2:0]    mode, mode_n;
  logic          illegal, illegal_n;
  logic          last, accept, legal;
  logic          high_mode, store_a, load_a, sp_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      step    <= '0;
      mode    <= 3'b000;
      illegal <= 1'b0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      mode    <= mode_n;
      illegal <= illegal_n;
    end
  end

  always_comb begin
    high_mode = ~mode[2] & mode[1];
    store_a   = ~mode[2] & ~mode[0];
    load_a    = ~mode[2] & mode[0];
`ifdef ABS_TRANSFER_SP_STORE_EN
    sp_store  = (mode == 3'b100);
    legal     = ~bus.mode[2] | (bus.mode == 3'b100);
`else
    sp_store  = 1'b0;
    legal     = ~bus.mode[2];
`endif
  end

  // The final FETCH step samples start exactly like IDLE so ops can run back to back.
  always_comb begin
    state_n   = state;
    step_n    = step;
    mode_n    = mode;
    illegal_n = 1'b0;
    last      = (step == LAST);
    accept    = (state == IDLE) || ((state == FETCH) && last);
    if (state != IDLE) step_n = last ? '0 : step + STEP1;
    case (state)
      IMM_LO:  if (last) state_n = high_mode ? DATA_LO : IMM_HI;
      IMM_HI:  if (last) state_n = DATA_LO;
      DATA_LO: if (last) begin
        state_n = FETCH;
`ifdef ABS_TRANSFER_SP_STORE_EN
        if (sp_store) state_n = DATA_HI;
`endif
      end
`ifdef ABS_TRANSFER_SP_STORE_EN
      DATA_HI: if (last) state_n = FETCH;
`endif
      FETCH:   if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (accept && bus.start) begin
      if (legal) begin
        state_n = IMM_LO;
        step_n  = '0;
        mode_n  = bus.mode;
      end else begin
        illegal_n = 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.done        = (state == FETCH) && last;
    bus.illegal     = illegal;
    bus.ir_fetch    = (state == FETCH);
    bus.write8      = '0;
    bus.read16      = '0;
    bus.write16     = '0;
    bus.read_alu8   = '0;
    bus.write_alu8  = '0;
    bus.read_sp     = '0;
    bus.move_reg    = 1'b0;
    bus.bus_in      = 1'b0;
    bus.bus_out     = 1'b0;
    bus.address_out = 1'b0;
    bus.high_page   = 1'b0;
    bus.increment16 = '0;
    case (state)
      IMM_LO, IMM_HI: begin
        if (step == '0) begin
          bus.read16[5]   = 1'b1;
          bus.address_out = 1'b1;
          bus.bus_in      = 1'b1;
          if (state == IMM_LO) bus.write8[0] = 1'b1;
          else                 bus.write8[1] = 1'b1;
        end else if (step == STEP1) begin
          bus.write16[5]     = 1'b1;
          bus.increment16[0] = 1'b1;
        end
      end
      DATA_LO: begin
        if (step == '0) begin
          bus.read16[0]   = 1'b1;
          bus.address_out = 1'b1;
          bus.high_page   = high_mode;
          if (store_a) begin
            bus.read_alu8[0] = 1'b1;
            bus.move_reg     = 1'b1;
            bus.bus_out      = 1'b1;
          end
          if (load_a) begin
            bus.write_alu8[0] = 1'b1;
            bus.bus_in        = 1'b1;
          end
`ifdef ABS_TRANSFER_SP_STORE_EN
          if (sp_store) begin
            bus.read_sp[0] = 1'b1;
            bus.bus_out    = 1'b1;
          end
`endif
        end else if (step == STEP1) begin
          bus.increment16[1] = sp_store;
        end
      end
`ifdef ABS_TRANSFER_SP_STORE_EN
      DATA_HI: begin
        if (step == '0) begin
          bus.read16[0]   = 1'b1;
          bus.address_out = 1'b1;
          bus.read_sp[1]  = 1'b1;
          bus.bus_out     = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign page_addr = bus.high_page ? HIGH_PAGE : 8'h00;
  assign dbg_state = state;
endmodule

// File: tb/tb_abs_transfer_sequencer.sv
// Scoreboard bench for abs_transfer_sequencer at STEPS=2, 4 and 8 (index 0, 1, 2).
// Probes hold hand-computed strobe snapshots per edge; events hold done/illegal edges.
module tb_abs_transfer_sequencer;
  localparam int OW = 45;
  localparam int EW = 36;

  typedef struct packed {
    logic [1:0]    d;
    int            at;
    logic [OW-1:0] vec;
  } probe_t;

  // {busy,done,illegal,fetch}, write8, read16, write16, ralu, walu, rsp,
  // {move,bus_in,bus_out,addr_out,high_page}, inc16, page_addr
  localparam logic [OW-1:0] V_ZERO   = '0;
  localparam logic [OW-1:0] V_BUSY   = {4'b1000, 8'h00, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_FETCH  = {4'b1001, 8'h00, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_DONE   = {4'b1101, 8'h00, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_ILL    = {4'b0010, 8'h00, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_IMM_LO = {4'b1000, 8'h01, 6'b100000, 6'h00, 2'b00, 2'b00, 2'b00, 5'b01010, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_IMM_HI = {4'b1000, 8'h02, 6'b100000, 6'h00, 2'b00, 2'b00, 2'b00, 5'b01010, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_IMM1   = {4'b1000, 8'h00, 6'h00, 6'b100000, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b01, 8'h00};
  localparam logic [OW-1:0] V_ST16   = {4'b1000, 8'h00, 6'b000001, 6'h00, 2'b01, 2'b00, 2'b00, 5'b10110, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_STHI   = {4'b1000, 8'h00, 6'b000001, 6'h00, 2'b01, 2'b00, 2'b00, 5'b10111, 2'b00, 8'hFF};
  localparam logic [OW-1:0] V_LD16   = {4'b1000, 8'h00, 6'b000001, 6'h00, 2'b00, 2'b01, 2'b00, 5'b01010, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_LDHI   = {4'b1000, 8'h00, 6'b000001, 6'h00, 2'b00, 2'b01, 2'b00, 5'b01011, 2'b00, 8'hFF};
  localparam logic [OW-1:0] V_SPLO   = {4'b1000, 8'h00, 6'b000001, 6'h00, 2'b00, 2'b00, 2'b01, 5'b00110, 2'b00, 8'h00};
  localparam logic [OW-1:0] V_SPINC  = {4'b1000, 8'h00, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 5'b00000, 2'b10, 8'h00};
  localparam logic [OW-1:0] V_SPHI   = {4'b1000, 8'h00, 6'b000001, 6'h00, 2'b00, 2'b00, 2'b10, 5'b00110, 2'b00, 8'h00};

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [EW-1:0] exp_q[$];
  probe_t        probe_q[$];
  logic [OW-1:0] obs [3];
  logic [7:0]    pg [3];
  logic [2:0]    st [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  abs_transfer_sequencer_if b0();
  abs_transfer_sequencer_if b1();
  abs_transfer_sequencer_if b2();

  abs_transfer_sequencer #(.STEPS(2)) u0 (.clk(clk), .rst(rst), .bus(b0), .page_addr(pg[0]), .dbg_state(st[0]));
  abs_transfer_sequencer #(.STEPS(4)) u1 (.clk(clk), .rst(rst), .bus(b1), .page_addr(pg[1]), .dbg_state(st[1]));
  abs_transfer_sequencer #(.STEPS(8)) u2 (.clk(clk), .rst(rst), .bus(b2), .page_addr(pg[2]), .dbg_state(st[2]));

  assign obs[0] = {b0.busy, b0.done, b0.illegal, b0.ir_fetch, b0.write8, b0.read16, b0.write16, b0.read_alu8, b0.write_alu8, b0.read_sp, b0.move_reg, b0.bus_in, b0.bus_out, b0.address_out, b0.high_page, b0.increment16, pg[0]};
  assign obs[1] = {b1.busy, b1.done, b1.illegal, b1.ir_fetch, b1.write8, b1.read16, b1.write16, b1.read_alu8, b1.write_alu8, b1.read_sp, b1.move_reg, b1.bus_in, b1.bus_out, b1.address_out, b1.high_page, b1.increment16, pg[1]};
  assign obs[2] = {b2.busy, b2.done, b2.illegal, b2.ir_fetch, b2.write8, b2.read16, b2.write16, b2.read_alu8, b2.write_alu8, b2.read_sp, b2.move_reg, b2.bus_in, b2.bus_out, b2.address_out, b2.high_page, b2.increment16, pg[2]};

  // Monitor: events pop the expected queue, probes fire on their edge.
  probe_t        p;
  logic [EW-1:0] e;
  logic [1:0]    kind;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (obs[d][OW-2] === 1'b1 || obs[d][OW-3] === 1'b1) begin
        kind = {obs[d][OW-3], obs[d][OW-2]};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event dut%0d: got kind=%b at edge %0d, required no event", d, kind, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {2'(d), kind, cyc}) begin
            failures++;
            $display("FAIL event dut%0d: got kind=%b edge=%0d, required dut%0d kind=%b edge=%0d",
                     d, kind, cyc, e[35:34], e[33:32], e[31:0]);
          end
        end
      end
    end
    while (probe_q.size() != 0 && probe_q[0].at <= cyc) begin
      p = probe_q.pop_front();
      checks++;
      if (p.at != cyc || obs[p.d] !== p.vec) begin
        failures++;
        $display("FAIL probe dut%0d edge %0d: got %h required %h", p.d, p.at, obs[p.d], p.vec);
      end
    end
  end

  task automatic drive(input int d, input logic s, input logic [2:0] m);
    case (d)
      0: begin b0.start = s; b0.mode = m; end
      1: begin b1.start = s; b1.mode = m; end
      default: begin b2.start = s; b2.mode = m; end
    endcase
  endtask

  task automatic probe(input int d, input int at, input logic [OW-1:0] vec);
    probe_t t;
    t.d = 2'(d);
    t.at = at;
    t.vec = vec;
    probe_q.push_back(t);
  endtask

  task automatic expect_ev(input int d, input logic [1:0] k, input int at);
    exp_q.push_back({2'(d), k, at});
  endtask

  // Called at a negedge: raises start so the next edge (returned in s) samples it.
  task automatic begin_op(input int d, input logic [2:0] m, output int s);
    drive(d, 1'b1, m);
    s = cyc + 1;
  endtask

  task automatic end_op(input int d);
    @(negedge clk);
    drive(d, 1'b0, 3'b000);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || probe_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || probe_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d events and %0d probes pending, required 0", exp_q.size(), probe_q.size());
      exp_q.delete();
      probe_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 3'b000);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) probe(d, cyc + 1, V_ZERO);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // STEPS=2, mode 000: 8-edge latency
    begin_op(0, 3'b000, s);
    probe(0, s + 1, V_IMM1); probe(0, s + 2, V_IMM_HI); probe(0, s + 4, V_ST16);
    probe(0, s + 5, V_BUSY); probe(0, s + 6, V_FETCH); probe(0, s + 7, V_DONE); probe(0, s + 8, V_ZERO);
    expect_ev(0, 2'b01, s + 7);
    end_op(0); wait_drain();

    // STEPS=8, mode 000: 32-edge latency, no strobes past step 1
    begin_op(2, 3'b000, s);
    probe(2, s + 1, V_IMM1); probe(2, s + 2, V_BUSY); probe(2, s + 7, V_BUSY); probe(2, s + 8, V_IMM_HI);
    probe(2, s + 16, V_ST16); probe(2, s + 17, V_BUSY); probe(2, s + 18, V_BUSY);
    probe(2, s + 24, V_FETCH); probe(2, s + 31, V_DONE);
    expect_ev(2, 2'b01, s + 31);
    end_op(2); wait_drain();

    // STEPS=4, mode 000
    begin_op(1, 3'b000, s);
    probe(1, s, V_IMM_LO); probe(1, s + 1, V_IMM1); probe(1, s + 2, V_BUSY); probe(1, s + 4, V_IMM_HI);
    probe(1, s + 5, V_IMM1); probe(1, s + 8, V_ST16); probe(1, s + 9, V_BUSY); probe(1, s + 12, V_FETCH);
    probe(1, s + 15, V_DONE); probe(1, s + 16, V_ZERO);
    expect_ev(1, 2'b01, s + 15);
    end_op(1); wait_drain();

    // mode 011: LDH A,(a8)
    begin_op(1, 3'b011, s);
    probe(1, s, V_IMM_LO); probe(1, s + 4, V_LDHI); probe(1, s + 5, V_BUSY);
    probe(1, s + 8, V_FETCH); probe(1, s + 11, V_DONE); probe(1, s + 12, V_ZERO);
    expect_ev(1, 2'b01, s + 11);
    end_op(1); wait_drain();

    // mode 010: LDH (a8),A
    begin_op(1, 3'b010, s);
    probe(1, s + 4, V_STHI); probe(1, s + 11, V_DONE);
    expect_ev(1, 2'b01, s + 11);
    end_op(1); wait_drain();

    // mode 001: LD A,(a16)
    begin_op(1, 3'b001, s);
    probe(1, s + 4, V_IMM_HI); probe(1, s + 8, V_LD16); probe(1, s + 15, V_DONE);
    expect_ev(1, 2'b01, s + 15);
    end_op(1); wait_drain();

    // mode 100: LD (a16),SP only when built in
    begin_op(1, 3'b100, s);
`ifdef ABS_TRANSFER_SP_STORE_EN
    probe(1, s + 4, V_IMM_HI); probe(1, s + 8, V_SPLO); probe(1, s + 9, V_SPINC); probe(1, s + 10, V_BUSY);
    probe(1, s + 12, V_SPHI); probe(1, s + 13, V_BUSY); probe(1, s + 16, V_FETCH);
    probe(1, s + 19, V_DONE); probe(1, s + 20, V_ZERO);
    expect_ev(1, 2'b01, s + 19);
`else
    probe(1, s, V_ILL); probe(1, s + 1, V_ZERO);
    expect_ev(1, 2'b10, s);
`endif
    end_op(1); wait_drain();

    // mode 111 is never legal
    begin_op(1, 3'b111, s);
    probe(1, s, V_ILL); probe(1, s + 1, V_ZERO);
    expect_ev(1, 2'b10, s);
    end_op(1); wait_drain();

    // start held through an op, mode changed mid-op; second op starts right after done
    begin_op(1, 3'b000, s);
    probe(1, s + 8, V_ST16); probe(1, s + 15, V_DONE); probe(1, s + 16, V_IMM_LO);
    probe(1, s + 24, V_LD16); probe(1, s + 31, V_DONE); probe(1, s + 32, V_ZERO);
    expect_ev(1, 2'b01, s + 15); expect_ev(1, 2'b01, s + 31);
    repeat (2) @(negedge clk);
    drive(1, 1'b1, 3'b001);
    while (cyc < s + 16) @(negedge clk);
    drive(1, 1'b0, 3'b000);
    wait_drain();

    // reset during IMM_HI step 2 aborts without done; a fresh op then completes
    begin_op(1, 3'b000, s);
    probe(1, s + 6, V_BUSY); probe(1, s + 7, V_ZERO);
    end_op(1);
    while (cyc < s + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin_op(1, 3'b010, s);
    probe(1, s, V_IMM_LO); probe(1, s + 4, V_STHI); probe(1, s + 11, V_DONE);
    expect_ev(1, 2'b01, s + 11);
    end_op(1); wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/abs_transfer_sequencer.md
# abs_transfer_sequencer

Self-timed microcode sequencer for the Game Boy CPU's absolute-address memory transfers between A (or SP) and memory: LD (a16),A, LD A,(a16), LDH (a8),A, LDH A,(a8), and optionally LD (a16),SP. It owns its M-cycle and T-step counters instead of taking them from the control unit, and drives the same strobe bundle the other microcode blocks feed into the control-unit OR-tree. The control unit only issues a start pulse with a mode, then waits for the done pulse.

## Interface
- STEPS, default 4: T-steps per M-cycle, legal range 2..8.
- HIGH_PAGE, default 8'hFF: high address byte used by the LDH modes.

- i_Clk, in, 1: clock; every register updates on the rising edge.
- i_Reset, in, 1: synchronous, active-high reset.
- i_Start, in, 1: start request; sampled only in IDLE.
- i_Mode, in, 3: operation, sampled with i_Start:
  - 000 = store A to (a16)
  - 001 = load A from (a16)
  - 010 = store A to (HIGH_PAGE:a8)
  - 011 = load A from (HIGH_PAGE:a8)
  - 100 = store SP to (a16); only with the Configuration macro.
- o_Busy, out, 1: high in every non-IDLE state.
- o_Done, out, 1: one-cycle pulse on the final step of FETCH.
- o_Illegal, out, 1: one-cycle pulse when a start arrives with an unsupported mode.
- o_IR_Fetch, out, 1: high for the whole FETCH M-cycle.
- o_Write8, out, 8: 8-bit register latch strobes. [0] latches the bus into Z, [1] into W. Other bits are 0.
- o_Read16, out, 6: 16-bit register address select. [5] = PC, [0] = WZ. Other bits are 0.
- o_Write16, out, 6: 16-bit register writeback. [5] = PC.
- o_ReadALU8, out, 2: [0] reads A onto the internal data path.
- o_WriteALU8, out, 2: [0] writes A from the bus.
- o_Read_SP, out, 2: [0] selects SP low byte, [1] selects SP high byte.
- o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out, out, 1 each: data-path move, bus-to-core, core-to-bus, address-drive strobes.
- o_High_Page, out, 1: forces the address high byte to HIGH_PAGE.
- o_Increment16, out, 2: [0] = increment the selected PC, [1] = increment WZ.

## Operation
- States: IDLE, IMM_LO, IMM_HI, DATA_LO, DATA_HI, FETCH.
- Per-mode state paths:
  - Modes 000/001: IMM_LO → IMM_HI → DATA_LO → FETCH.
  - Modes 010/011: IMM_LO → DATA_LO → FETCH.
  - Mode 100: IMM_LO → IMM_HI → DATA_LO → DATA_HI → FETCH.
- Step counter: counts 0..STEPS-1 in every non-IDLE state. The state advances when the count reaches STEPS-1, and the counter then wraps to 0.
- IMM_LO / IMM_HI:
  - Step 0: o_Read16[5], o_Address_Out, o_Bus_In, and o_Write8[0] (IMM_LO) or o_Write8[1] (IMM_HI).
  - Step 1: o_Write16[5] and o_Increment16[0].
- DATA_LO, step 0: o_Read16[0] and o_Address_Out, plus o_High_Page in modes 010/011. Then per mode:
  - Store A: o_ReadALU8[0], o_Move_Reg, o_Bus_Out.
  - Load A: o_WriteALU8[0], o_Bus_In.
  - SP store: o_Read_SP[0] and o_Bus_Out.
- DATA_LO, step 1 (SP store only): o_Increment16[1].
- DATA_HI, step 0: o_Read16[0], o_Address_Out, o_Read_SP[1], o_Bus_Out.
- All strobes are combinational decodes of the registered state, step and latched mode. Every strobe is 0 in IDLE and on steps not listed above.
- Illegal mode: no state change and no strobes. o_Illegal pulses in the cycle after the start, and o_Busy stays 0.

## Timing
- Reset: state IDLE, step 0, latched mode 000, every output 0. Reset mid-operation aborts on the next edge, with no o_Done.
- Latency, measured as clock edges from i_Start sampled to o_Done high:
  - Modes 000/001: 4·STEPS.
  - Modes 010/011: 3·STEPS.
  - Mode 100: 5·STEPS.
- Back-to-back: i_Start high in the same cycle as o_Done is accepted. The next cycle is IMM_LO step 0, with no idle gap. This start is taken because the last FETCH step behaves as IDLE for start sampling.
- i_Start while busy (other than in the o_Done cycle) is ignored, and i_Mode is not resampled.
- Counter width is $clog2(STEPS); no counter ever exceeds STEPS-1.

## Configuration
- ABS_TRANSFER_SP_STORE_EN defined: mode 100 is legal, and the DATA_HI state and o_Read_SP logic are built.
- Not defined: DATA_HI is removed, o_Read_SP is tied to 0, and mode 100 raises o_Illegal like 101–111.

## Test plan
- STEPS=4, reset, start mode 000 → after 4 edges IMM_LO step 0 with o_Read16=6'b100000, o_Write8=8'h01. o_Done arrives at edge 16. A value 8'h5A is driven out on the DATA_LO step 0 cycle.
- Mode 011, bus byte 8'h44 on IMM_LO step 0 → DATA_LO step 0 has o_High_Page=1 and o_WriteALU8=2'b01. o_Done arrives at edge 12.
- Macro defined, mode 100 → DATA_LO step 1 has o_Increment16=2'b10, and DATA_HI step 0 has o_Read_SP=2'b10. o_Done arrives at edge 20. Macro undefined, mode 100 → o_Illegal pulse, o_Busy=0.
- i_Start held high through a mode-000 op, with i_Mode changed to 001 mid-op → behaves as mode 000. A second op starts in the cycle after o_Done with no IDLE cycle.
- i_Reset asserted during IMM_HI step 2 → all outputs 0 on the next cycle. No o_Done; a fresh start then completes normally.
- STEPS=2 and STEPS=8 → latencies of 8 and 32 edges for mode 000, with strobes only on steps 0 and 1.
